// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write/read/clear bus between a datapath master and regfile_mp.
interface regfile_mp_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int ADDR_W = $clog2(DEPTH)
);
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic                     clear;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_ack;
    logic [NUM_RD-1:0]        rd_hit;
    logic                     wr_conflict;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, clear,
        input  rd_data, rd_ack, rd_hit, wr_conflict
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, clear,
        output rd_data, rd_ack, rd_hit, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with registered reads and written flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (or clear) to reads.
module regfile_mp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input logic         clock,
    input logic         reset,
    regfile_mp_if.slave bus
);
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             written;
    logic [DEPTH-1:0]             we;
    logic [DEPTH-1:0][DATA_W-1:0] wd;
    logic                         conflict;
    logic [NUM_RD*DATA_W-1:0]     rd_data_d;
    logic [NUM_RD-1:0]            rd_hit_d;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction

    // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
    always_comb begin
        we = '0;
        wd = '0;
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_valid[i] && in_range(bus.wr_addr[i*ADDR_W +: ADDR_W])) begin
                conflict = conflict | we[bus.wr_addr[i*ADDR_W +: ADDR_W]];
                we[bus.wr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
                wd[bus.wr_addr[i*ADDR_W +: ADDR_W]] = bus.wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem     <= '0;
            written <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (we[e]) begin
                    mem[e]     <= wd[e];
                    written[e] <= 1'b1;
                end else if (bus.clear) begin
                    mem[e]     <= '0;
                    written[e] <= 1'b0;
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        wire [ADDR_W-1:0] ra = bus.rd_addr[j*ADDR_W +: ADDR_W];
        wire              ok = in_range(ra);
        logic [DATA_W-1:0] rv;
        logic              rh;
`ifdef REGFILE_BYPASS_EN
        assign rv = !ok ? '0 : we[ra] ? wd[ra] : bus.clear ? '0 : mem[ra];
        assign rh = ok && (we[ra] || (!bus.clear && written[ra]));
`else
        assign rv = ok ? mem[ra] : '0;
        assign rh = ok && written[ra];
`endif
        assign rd_data_d[j*DATA_W +: DATA_W] = bus.rd_valid[j] ? rv : bus.rd_data[j*DATA_W +: DATA_W];
        assign rd_hit_d[j] = bus.rd_valid[j] ? rh : bus.rd_hit[j];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.rd_data     <= '0;
            bus.rd_ack      <= '0;
            bus.rd_hit      <= '0;
            bus.wr_conflict <= 1'b0;
        end else begin
            bus.rd_data     <= rd_data_d;
            bus.rd_ack      <= bus.rd_valid;
            bus.rd_hit      <= rd_hit_d;
            bus.wr_conflict <= conflict;
        end
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the team's 8x8 single-port regfile.
- Configurable data width, depth, read-port count and write-port count.
- Adds registered read ports, deterministic write-port priority with conflict reporting, per-entry written flags and a bulk clear.
- Sits beside the datapath as architectural/scratch state storage.

Parameters:
- DATA_W, 8, bits per entry.
- DEPTH, 8, number of entries; need not be a power of two (minimum 2).
- NUM_RD, 2, number of read ports (minimum 1).
- NUM_WR, 2, number of write ports (minimum 1).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_valid  input  NUM_WR  per-port write request.
- wr_addr  input  NUM_WR*ADDR_W  write addresses, packed; port i at [i*ADDR_W +: ADDR_W].
- wr_data  input  NUM_WR*DATA_W  write data, packed the same way.
- rd_valid  input  NUM_RD  per-port read request.
- rd_addr  input  NUM_RD*ADDR_W  read addresses, packed.
- clear  input  1  invalidate and zero all entries.
- rd_data  output  NUM_RD*DATA_W  registered read data.
- rd_ack  output  NUM_RD  registered; high the cycle rd_data is updated.
- rd_hit  output  NUM_RD  registered; addressed entry was written since the last reset or clear.
- wr_conflict  output  1  registered pulse; two or more valid write ports targeted the same in-range address in the previous cycle.

Behaviour:
- Reset: all entries 0; all written flags 0; rd_data 0; rd_ack 0; rd_hit 0; wr_conflict 0.
- Reset has priority over every other input, including mid-operation writes, reads and clear.
- Writes:
  - A valid write updates the entry and sets its written flag at the next edge.
  - Same-address writes from multiple ports: the highest-indexed port wins.
  - A same-address collision sets wr_conflict high for exactly the next cycle.
  - Writes to different addresses from multiple ports all commit.
- Reads:
  - Read latency is 1 cycle. rd_valid[j] in cycle N gives rd_data[j], rd_hit[j] and rd_ack[j]=1 in cycle N+1.
  - When rd_valid[j]=0: rd_ack[j]=0 next cycle; rd_data[j] and rd_hit[j] hold their previous values.
  - Any number of read ports may read the same address in the same cycle.
- Out-of-range address (addr >= DEPTH):
  - Write is ignored and excluded from conflict detection.
  - Read returns rd_data=0, rd_hit=0, rd_ack=1.
- Clear:
  - At the next edge, all entries and written flags go to 0.
  - A write in the same cycle as clear wins for its address: that entry holds the new data with written=1.
  - A read in the same cycle as clear returns the pre-clear contents (subject to the bypass rule below).
- Read/write in the same cycle, same address: result is governed by REGFILE_BYPASS_EN.
- No stall and no backpressure: every request completes in one cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read of an address being written in the same cycle returns the winning write data, with rd_hit=1.
  - Clear in the same cycle without a write to that address forwards 0 with rd_hit=0.
- Undefined: such a read returns the pre-write contents and pre-write written flag (read-before-write).

Test Plan:
- Reset, then read address 3 on both ports -> next cycle rd_ack=2'b11, rd_data=0, rd_hit=0, wr_conflict=0.
- Port0 writes 8'hA5 to addr 2, port1 writes 8'h3C to addr 5 in the same cycle; read both next cycle -> rd_data 8'hA5 and 8'h3C, rd_hit=1, wr_conflict=0.
- Port0 writes 8'h11 and port1 writes 8'h22, both to addr 4 -> wr_conflict=1 for one cycle; a later read of addr 4 returns 8'h22.
- Write 8'h77 to addr 1 while reading addr 1 in the same cycle -> with REGFILE_BYPASS_EN, rd_data=8'h77 and rd_hit=1; without it, old value (0 after reset) and rd_hit=0.
- Fill all 8 entries, assert clear with port0 writing 8'h5A to addr 6 in the same cycle -> reads show addr 6 = 8'h5A with rd_hit=1; every other entry 0 with rd_hit=0.
- DEPTH=6 build: write addr 7 and read addr 7 -> no entry changes; read gives rd_data=0, rd_hit=0, rd_ack=1.
  - Then assert reset during a write burst -> all outputs 0 on the next cycle; no write from the reset cycle persists.
